// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall controller driving PC stop, FD nop/flush, DE hold/flush and EX hold.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rs1_addr, rs2_addr               decode source register indices
//   rs1_read, rs2_read               decode instruction reads rs1 / rs2
//   rd_addr, mem_read                execute destination index, execute instruction is a load
//   jump                             taken branch/jump resolved in execute
//   mdu_start, mdu_done              multi-cycle MDU start pulse / result valid
//   mem_req, mem_ready               outstanding data access / access completes this cycle
//   pc_stop, fd_nop, fd_flush        PC hold, FD hold, FD load zero
//   de_hold, de_flush, ex_hold       DE hold, DE bubble, EM hold with EX frozen
//   mem_timeout                      watchdog pulse on leaving a too-long memory wait
//   stall_cnt                        number of cycles with pc_stop asserted since reset
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic             rs1_read,
    input  logic             rs2_read,
    input  logic [4:0]       rd_addr,
    input  logic             mem_read,
    input  logic             jump,
    input  logic             mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stop,
    output logic             fd_nop,
    output logic             fd_flush,
    output logic             de_hold,
    output logic             de_flush,
    output logic             ex_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;
    state_t state, state_nxt;
    logic [WW-1:0] cnt, cnt_nxt;
    logic hold, flush, lu, to;
    wire load_use = mem_read && rd_addr != 5'd0 &&
                    ((rs1_read && rs1_addr == rd_addr) || (rs2_read && rs2_addr == rd_addr));
    always_comb begin
        hold      = 1'b0;
        flush     = 1'b0;
        lu        = 1'b0;
        to        = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    hold      = 1'b1;
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = WW'(1);
                end else if (mdu_start) begin
                    hold      = 1'b1;
                    state_nxt = MDU_WAIT;
                end else if (jump) begin
                    flush = 1'b1;
                end else begin
                    lu = load_use;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt == WW'(MEM_TIMEOUT - 1)) begin
                    to        = 1'b1;
                    flush     = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    hold    = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            MDU_WAIT: begin
                hold      = !mdu_done;
                state_nxt = mdu_done ? RUN : MDU_WAIT;
            end
            default: state_nxt = RUN;
        endcase
    end
    // Outputs are combinational, so the asynchronous reset must also mask them directly.
    assign pc_stop     = rst_n && (hold || lu);
    assign fd_nop      = rst_n && (hold || lu);
    assign fd_flush    = rst_n && flush;
    assign de_hold     = rst_n && hold;
    assign de_flush    = rst_n && (flush || lu);
    assign ex_hold     = rst_n && hold;
    assign mem_timeout = rst_n && to;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stall_cnt <= stall_cnt + CNT_W'(pc_stop);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl with directed scenarios and random traffic.
module tb_pipeline_ctrl;
    localparam int MT = 16;
    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1, rs2;
        logic       r1, r2;
        logic [4:0] rd;
        logic       mr, j, ms, md, mq, my;
    } in_t;
    typedef struct packed {
        logic [6:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;
    localparam logic [6:0] HOLD = 7'b1101010;
    localparam logic [6:0] FLSH = 7'b0010100;
    localparam logic [6:0] LUSE = 7'b1100100;
    localparam logic [6:0] TOUT = 7'b0010101;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic rs1_read = 0, rs2_read = 0, mem_read = 0, jump = 0, mdu_start = 0;
    logic mdu_done = 0, mem_req = 0, mem_ready = 0;
    logic pc_stop, fd_nop, fd_flush, de_hold, de_flush, ex_hold, mem_timeout;
    logic [31:0] stall_cnt;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int mode = 0;
    int held = 0;
    logic [31:0] scnt = '0;
    pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_read(rs1_read), .rs2_read(rs2_read),
        .rd_addr(rd_addr), .mem_read(mem_read), .jump(jump), .mdu_start(mdu_start),
        .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stop(pc_stop), .fd_nop(fd_nop), .fd_flush(fd_flush), .de_hold(de_hold),
        .de_flush(de_flush), .ex_hold(ex_hold), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    function automatic in_t idle();
        in_t v = '0;
        v.rst_n = 1'b1;
        return v;
    endfunction
    // Reference: mode 0 = running, 1 = waiting on memory, 2 = waiting on MDU.
    task automatic step(input in_t v);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        {rst_n, rs1_addr, rs2_addr, rs1_read, rs2_read, rd_addr,
         mem_read, jump, mdu_start, mdu_done, mem_req, mem_ready} = v;
        e = '0;
        if (!v.rst_n) begin
            mode = 0;
            held = 0;
            scnt = '0;
        end else if (mode == 0) begin
            lu = v.mr && v.rd != 0 && ((v.r1 && v.rs1 == v.rd) || (v.r2 && v.rs2 == v.rd));
            if (v.mq && !v.my) begin
                e.ctrl = HOLD;
                mode = 1;
                held = 1;
            end else if (v.ms) begin
                e.ctrl = HOLD;
                mode = 2;
            end else if (v.j) e.ctrl = FLSH;
            else if (lu) e.ctrl = LUSE;
        end else if (mode == 1) begin
            if (v.my) mode = 0;
            else if (held == MT - 1) begin
                e.ctrl = TOUT;
                mode = 0;
            end else begin
                e.ctrl = HOLD;
                held++;
            end
        end else begin
            if (v.md) mode = 0;
            else e.ctrl = HOLD;
        end
        e.cnt = scnt;
        q.push_back(e);
        if (e.ctrl[6]) scnt = scnt + 1;
    endtask
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                got = {pc_stop, fd_nop, fd_flush, de_hold, de_flush, ex_hold, mem_timeout};
                checks++;
                if (got !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got, e.ctrl);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.cnt);
                end
            end
        end
    end
    initial begin
        in_t v;
        in_t r;
        r = idle();
        r.rst_n = 1'b0;
        step(r);
        step(r);
        v = idle(); v.mr = 1; v.rd = 5; v.rs2 = 5; v.r2 = 1;
        step(v);
        step(idle());
        v.rd = 0; v.rs2 = 0;
        step(v);
        v.rd = 7; v.rs1 = 7; v.r1 = 1; v.rs2 = 0; v.r2 = 0; v.j = 1;
        step(v);
        step(idle());
        v = idle(); v.mq = 1;
        repeat (3) step(v);
        v.my = 1;
        step(v);
        step(idle());
        v = idle(); v.mq = 1;
        repeat (17) step(v);
        step(idle());
        v = idle(); v.ms = 1;
        step(v);
        v = idle(); v.j = 1;
        repeat (7) step(v);
        v.md = 1;
        step(v);
        step(idle());
        v = idle(); v.ms = 1;
        step(v);
        repeat (3) step(idle());
        step(r);
        step(idle());
        v = idle(); v.mq = 1;
        step(v);
        repeat (MT + 2) step(r);
        for (int i = 0; i < 3000; i++) begin
            v = idle();
            v.rst_n = ($urandom_range(0, 199) != 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.r1 = 1'($urandom); v.r2 = 1'($urandom); v.mr = 1'($urandom);
            v.j  = ($urandom_range(0, 5) == 0);
            v.ms = ($urandom_range(0, 9) == 0);
            v.md = ($urandom_range(0, 5) == 0);
            v.mq = (mode == 1) || ($urandom_range(0, 7) == 0);
            v.my = ($urandom_range(0, 7) == 0);
            step(v);
        end
        @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
